// File: rtl/wbu_if.sv
// Write-back unit bus: LSU-side entry handshake plus retirement, register-file
// and CSR write ports. "slave" is the wbu side, "master" is the environment.
interface wbu_if;
  logic        valid_last;
  logic        ready_last;
  logic        R_wen;
  logic        mem_ren;
  logic        jump_flag;
  logic [4:0]  rd;
  logic [31:0] rd_value;
  logic [31:0] LSU_Rdata;
  logic [31:0] Ex_result;
  logic [3:0]  csr_wen;
  logic        commit_valid;
  logic        commit_ready;
  logic        flush;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  csr_wen_o;
  logic [31:0] csr_wdata;
  logic        jump_commit;
  logic [63:0] instret;

  modport slave (
    input  valid_last, R_wen, mem_ren, jump_flag, rd, rd_value, LSU_Rdata,
           Ex_result, csr_wen, commit_ready, flush,
    output ready_last, commit_valid, rf_wen, rf_waddr, rf_wdata, csr_wen_o,
           csr_wdata, jump_commit, instret
  );

  modport master (
    output valid_last, R_wen, mem_ren, jump_flag, rd, rd_value, LSU_Rdata,
           Ex_result, csr_wen, commit_ready, flush,
    input  ready_last, commit_valid, rf_wen, rf_waddr, rf_wdata, csr_wen_o,
           csr_wdata, jump_commit, instret
  );
endinterface

// File: rtl/wbu.sv
// Write-back unit: 2-entry FIFO between the LSU and retirement. The head entry
// drives the register-file / CSR write ports in the cycle it is dequeued.
// Optional feature: define WBU_INSTRET_EN for a 64-bit retired-entry counter;
// otherwise instret is tied to zero and no counter flops exist.
module wbu (
  input  logic clock,
  input  logic reset,
  wbu_if.slave bus
);
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CSR_W  = 4;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned CNT_W_INSTRET = 64;

  typedef struct packed {
    logic              r_wen;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] wdata;
    logic [CSR_W-1:0]  csr_wen;
    logic [DATA_W-1:0] ex_result;
    logic              jump;
  } entry_t;

  entry_t           mem_q [2];
  logic             head_q;
  logic             tail_q;
  logic [CNT_W-1:0] count_q;
  logic             not_full;
  logic             not_empty;
  logic             enq;
  logic             deq;
  entry_t           head_e;

  // Occupancy-derived handshakes; no path from commit_ready to ready_last.
  assign not_full  = (count_q != CNT_W'(2));
  assign not_empty = (count_q != CNT_W'(0));
  assign enq       = bus.valid_last & not_full & ~bus.flush;
  assign deq       = not_empty & bus.commit_ready & ~bus.flush;
  assign head_e    = mem_q[head_q];

  assign bus.ready_last   = not_full;
  assign bus.commit_valid = not_empty;
  assign bus.rf_wen       = deq & head_e.r_wen & (head_e.rd != REG_W'(0));
  assign bus.rf_waddr     = head_e.rd;
  assign bus.rf_wdata     = head_e.wdata;
  assign bus.csr_wen_o    = deq ? head_e.csr_wen : CSR_W'(0);
  assign bus.csr_wdata    = head_e.ex_result;
  assign bus.jump_commit  = deq & head_e.jump;

  // Pointer/count bookkeeping; flush empties the buffer and rewinds pointers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= '0;
    end else if (bus.flush) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= '0;
    end else begin
      if (enq) tail_q <= ~tail_q;
      if (deq) head_q <= ~head_q;
      count_q <= count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  // Entry payload capture; load data replaces the ALU result for loads.
  always_ff @(posedge clock) begin
    if (enq) begin
      mem_q[tail_q] <= '{
        r_wen:     bus.R_wen,
        rd:        bus.rd,
        wdata:     bus.mem_ren ? bus.LSU_Rdata : bus.rd_value,
        csr_wen:   bus.csr_wen,
        ex_result: bus.Ex_result,
        jump:      bus.jump_flag
      };
    end
  end

`ifdef WBU_INSTRET_EN
  logic [CNT_W_INSTRET-1:0] instret_q;

  // Retired-entry counter; flushed entries never dequeue so are not counted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instret_q <= '0;
    end else if (deq) begin
      instret_q <= instret_q + CNT_W_INSTRET'(1);
    end
  end

  assign bus.instret = instret_q;
`else
  assign bus.instret = '0;
`endif
endmodule
